// File: rtl/led_status_ctrl.sv
// Purpose : N-channel status LED driver: off / on / shared synchronous blink / activity pulse-stretch.
// Latency : 1 cycle from mode_i, act_i or internal phase/stretch update to led_o; tick_o trails internal tick by 1.
// Backpress: none; free-running counters, every input level sampled each cycle.
//
// Ports:
//   clk_i   - system clock (only clock)
//   rst_ni  - asynchronous active-low reset
//   mode_i  - 2 bits per channel: 00 off, 01 on, 10 blink, 11 activity
//   act_i   - per-channel activity strobe, level sampled every cycle
//   tick_o  - registered one-cycle prescaler tick for slow housekeeping logic
//   led_o   - registered LED drive, inverted when ACTIVE_LOW=1
module led_status_ctrl #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned CLK_HZ        = 25_000_000,
  parameter int unsigned TICK_HZ       = 1000,
  parameter int unsigned BLINK_TICKS   = 500,
  parameter int unsigned STRETCH_TICKS = 50,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [2*CHANNELS-1:0] mode_i,
  input  logic [CHANNELS-1:0]   act_i,
  output logic                  tick_o,
  output logic [CHANNELS-1:0]   led_o
);

  localparam int unsigned DIV   = (TICK_HZ == 0) ? 0 : CLK_HZ / TICK_HZ;
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int unsigned STR_W = ($clog2(STRETCH_TICKS + 1) > 1) ? $clog2(STRETCH_TICKS + 1) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_TICKS - 1);
  localparam logic [STR_W-1:0] STR_LOAD   = STR_W'(STRETCH_TICKS);

  // Elaboration-time parameter sanity.
  if (DIV < 1) begin : g_bad_div
    $error("led_status_ctrl: CLK_HZ/TICK_HZ must be >= 1");
  end
  if (BLINK_TICKS < 1) begin : g_bad_blink
    $error("led_status_ctrl: BLINK_TICKS must be >= 1");
  end
  if (STRETCH_TICKS < 1) begin : g_bad_stretch
    $error("led_status_ctrl: STRETCH_TICKS must be >= 1");
  end
  if (CHANNELS < 1) begin : g_bad_channels
    $error("led_status_ctrl: CHANNELS must be >= 1");
  end

  logic [DIV_W-1:0]                presc_q, presc_d;
  logic [BLK_W-1:0]                blink_q, blink_d;
  logic                            phase_q, phase_d;
  logic [CHANNELS-1:0][STR_W-1:0]  stretch_q, stretch_d;
  logic                            tick_q, tick_d;
  logic [CHANNELS-1:0]             led_q, led_d;
  logic                            tick;
  logic [CHANNELS-1:0]             lit;

  // Prescaler: internal tick marks the last count of each DIV-cycle window.
  assign tick = (presc_q == DIV_LAST);

  always_comb begin
    presc_d = presc_q + 1'b1;
    if (tick) begin
      presc_d = '0;
    end
    tick_d = tick;
  end

  // Shared blink generator; never touched by mode changes so all blinking
  // channels stay in step.
  always_comb begin
    blink_d = blink_q;
    phase_d = phase_q;
    if (tick) begin
      if (blink_q == BLINK_LAST) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + 1'b1;
      end
    end
  end

  // Stretch counters run in every mode; a strobe reloads even on a tick cycle.
  always_comb begin
    stretch_d = stretch_q;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (act_i[k]) begin
        stretch_d[k] = STR_LOAD;
      end else if (tick && (stretch_q[k] != '0)) begin
        stretch_d[k] = stretch_q[k] - 1'b1;
      end
    end
  end

  // Per-channel lit function. act_i is ORed in directly so the LED lights on
  // the cycle after the strobe instead of waiting for the counter load.
  always_comb begin
    lit = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      case (mode_i[2*k +: 2])
        2'b00:   lit[k] = 1'b0;
        2'b01:   lit[k] = 1'b1;
        2'b10:   lit[k] = phase_q;
        default: lit[k] = act_i[k] | (stretch_q[k] != '0);
      endcase
    end
    led_d = lit ^ {CHANNELS{ACTIVE_LOW}};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q   <= '0;
      blink_q   <= '0;
      phase_q   <= 1'b0;
      stretch_q <= '0;
      tick_q    <= 1'b0;
      led_q     <= {CHANNELS{ACTIVE_LOW}};
    end else begin
      presc_q   <= presc_d;
      blink_q   <= blink_d;
      phase_q   <= phase_d;
      stretch_q <= stretch_d;
      tick_q    <= tick_d;
      led_q     <= led_d;
    end
  end

  assign tick_o = tick_q;
  assign led_o  = led_q;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Purpose : self-checking bench for led_status_ctrl, two instances (active-high and active-low pins).
// Latency : expectations derived from cycle index since reset release and the edge of the last strobe.
// Backpress: n/a.
module tb_led_status_ctrl;

  localparam int CH    = 4;
  localparam int DIV   = 10;   // CLK_HZ=100 / TICK_HZ=10
  localparam int BLINK = 3;
  localparam int STR   = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] mode  = '0;
  logic [3:0] act   = '0;
  logic       tick_a, tick_b;
  logic [3:0] led_a, led_b;

  always #5 clk = ~clk;

  led_status_ctrl #(
    .CHANNELS(CH), .CLK_HZ(100), .TICK_HZ(10),
    .BLINK_TICKS(BLINK), .STRETCH_TICKS(STR), .ACTIVE_LOW(1'b0)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .act_i(act),
    .tick_o(tick_a), .led_o(led_a)
  );

  led_status_ctrl #(
    .CHANNELS(CH), .CLK_HZ(100), .TICK_HZ(10),
    .BLINK_TICKS(BLINK), .STRETCH_TICKS(STR), .ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .act_i(act),
    .tick_o(tick_b), .led_o(led_b)
  );

  int checks = 0;
  int passed = 0;
  int n      = 0;          // clock edges since reset release
  int last_act [CH];       // edge at which each channel last sampled act=1 (-1: never)

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, n);
  endtask

  // Ticks take effect at edges DIV, 2*DIV, ...; after edge c, c/DIV ticks have occurred.
  function automatic bit model_phase(input int c);
    return ((c / DIV / BLINK) % 2) == 1;
  endfunction

  function automatic int model_stretch(input int k, input int c);
    int t;
    if (last_act[k] < 0) return 0;
    t = STR - (c / DIV - last_act[k] / DIV);
    return (t < 0) ? 0 : t;
  endfunction

  task automatic model_reset();
    n = 0;
    for (int k = 0; k < CH; k++) last_act[k] = -1;
  endtask

  // Drive one cycle of inputs, clock it, then compare both instances.
  task automatic step(input logic [7:0] m, input logic [3:0] a);
    logic [3:0] lit;
    logic [3:0] lit_n;
    logic [3:0] texp;
    mode = m;
    act  = a;
    for (int k = 0; k < CH; k++) begin
      case (m[2*k +: 2])
        2'b00:   lit[k] = 1'b0;
        2'b01:   lit[k] = 1'b1;
        2'b10:   lit[k] = model_phase(n);
        default: lit[k] = a[k] || (model_stretch(k, n) != 0);
      endcase
    end
    @(posedge clk);
    #1;
    n++;
    for (int k = 0; k < CH; k++) if (a[k]) last_act[k] = n;
    lit_n = ~lit;
    texp  = {3'b000, (n % DIV) == 0};
    chk("tick_a", {3'b000, tick_a}, texp);
    chk("tick_b", {3'b000, tick_b}, texp);
    chk("led_a",  led_a, lit);
    chk("led_b",  led_b, lit_n);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_led_a"},  led_a, 4'h0);
    chk({tag, "_led_b"},  led_b, 4'hF);
    chk({tag, "_tick_a"}, {3'b000, tick_a}, 4'h0);
    chk({tag, "_tick_b"}, {3'b000, tick_b}, 4'h0);
  endtask

  initial begin
    // Reset applied before any clock edge: outputs dark without a clock.
    #1 rst_n = 1'b0;
    mode = 8'hFF;
    #1;
    reset_checks("rst_noclk");
    repeat (3) begin
      @(posedge clk);
      #1;
      reset_checks("rst_hold");
    end
    rst_n = 1'b1;
    model_reset();

    // All channels blinking from a common phase; ch0 forced on mid-period.
    for (int i = 0; i < 75; i++) step(8'b1010_1010, 4'h0);
    for (int i = 0; i < 40; i++) step(8'b1010_1001, 4'h0);

    // Single activity pulse on ch1, others blinking.
    for (int i = 0; i < 3; i++) step(8'b1010_1110, 4'h0);
    step(8'b1010_1110, 4'b0010);
    for (int i = 0; i < 35; i++) step(8'b1010_1110, 4'h0);

    // Strobe collides with a tick (sampled on a tick edge), then retrigger before expiry.
    while ((n % DIV) != DIV - 1) step(8'b1010_1110, 4'h0);
    step(8'b1010_1110, 4'b0010);
    for (int i = 0; i < 14; i++) step(8'b1010_1110, 4'h0);
    step(8'b1010_1110, 4'b0010);
    for (int i = 0; i < 35; i++) step(8'b1010_1110, 4'h0);

    // Random modes and activity.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] m;
      logic [3:0] a;
      m = (i % 25 == 0) ? 8'($urandom) : mode;
      a = 4'($urandom) & 4'($urandom) & 4'($urandom);
      step(m, a);
    end

    // Static modes: random activity must not affect off/on channels.
    for (int i = 0; i < 220; i++) step(8'b00_01_00_01, 4'($urandom));

    // Reset asserted mid-blink: outputs go dark with no clock edge.
    for (int i = 0; i < 17; i++) step(8'b1010_1010, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    reset_checks("rst_async");
    @(posedge clk);
    #1;
    reset_checks("rst_async_hold");
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 70; i++) step(8'b1110_1010, 4'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
